// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multiphase clock generator.
package clkgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_PHASES = 2;

  // Counter width able to hold max(high_cyc, gap_cyc), never below 1 bit.
  function automatic int unsigned cnt_w(input int unsigned high_cyc,
                                        input int unsigned gap_cyc);
    int unsigned m;
    m = (high_cyc > gap_cyc) ? high_cyc : gap_cyc;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/multiphase_clock_gen_phase_timer.sv
// Loadable down-counter that flags terminal count; times HIGH and GAP intervals.
module phase_timer #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/multiphase_clock_gen.sv
// Rotating non-overlapping phase enables with run/stop, single-step and sync strobe.
module multiphase_clock_gen
  import clkgen_pkg::*;
#(
  parameter int unsigned PHASES   = DEFAULT_PHASES,
  parameter int unsigned HIGH_CYC = 1,
  parameter int unsigned GAP_CYC  = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      STEP,
  output logic [PHASES-1:0]         PH,
  output logic                      O_S,
  output logic [$clog2(PHASES)-1:0] PH_IDX,
  output logic                      BUSY
);

  localparam int unsigned IW = $clog2(PHASES);
  localparam int unsigned CW = cnt_w(HIGH_CYC, GAP_CYC);
  localparam logic [CW-1:0] HIGH_LD = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = (GAP_CYC > 0) ? CW'(GAP_CYC - 1) : '0;
  localparam logic [IW-1:0] LAST    = IW'(PHASES - 1);

  if (PHASES < 2 || PHASES > 16 || HIGH_CYC < 1 || HIGH_CYC > 255 || GAP_CYC > 255) begin : g_bad_params
    $error("multiphase_clock_gen: parameter out of range");
  end

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic            step_lat, step_n;
  logic            os_n;
  logic            load;
  logic [CW-1:0]   load_val;
  logic            done;
  logic            phase_end;
  logic [PHASES-1:0] ph_n;

  phase_timer #(.W(CW)) u_timer (
    .clk      (CLK),
    .rst      (RST),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    step_n    = step_lat;
    os_n      = 1'b0;
    load      = 1'b0;
    load_val  = HIGH_LD;
    phase_end = 1'b0;

    case (state)
      IDLE: begin
        if (EN || STEP) begin
          state_n = HIGH;
          idx_n   = '0;
          load    = 1'b1;
          os_n    = 1'b1;
          step_n  = STEP;
        end
      end
      HIGH: begin
        if (done) begin
          if (GAP_CYC > 0) begin
            state_n  = GAP;
            load     = 1'b1;
            load_val = GAP_LD;
          end else begin
            phase_end = 1'b1;
          end
        end
      end
      GAP:     phase_end = done;
      default: state_n = IDLE;
    endcase

    // Shared end-of-phase handling: advance, or decide run/stop at the major-cycle boundary.
    if (phase_end) begin
      load = 1'b1;
      if (idx != LAST) begin
        idx_n   = idx + IW'(1);
        state_n = HIGH;
      end else begin
        idx_n = '0;
        if (EN && !step_lat) begin
          state_n = HIGH;
          os_n    = 1'b1;
        end else begin
          state_n = IDLE;
          step_n  = 1'b0;
          load    = 1'b0;
        end
      end
    end
  end

  always_comb begin
    ph_n = '0;
    for (int unsigned i = 0; i < PHASES; i++) begin
      ph_n[i] = (state_n == HIGH) && (idx_n == IW'(i));
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      idx      <= '0;
      step_lat <= 1'b0;
      PH       <= '0;
      O_S      <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      step_lat <= step_n;
      PH       <= ph_n;
      O_S      <= os_n;
    end
  end

  assign PH_IDX = idx;
  assign BUSY   = (state != IDLE);

endmodule

// File: doc/multiphase_clock_gen.md
Name: multiphase_clock_gen

Overview:
- Parametrised successor to the two-phase clock generator.
- Produces PHASES non-overlapping phase enables from the single system clock CLK. Each enable is high for HIGH_CYC cycles, followed by GAP_CYC dead cycles, in rotating order 0..PHASES-1.
- Adds what the two-phase block lacks: run/stop control with a clean stop, single-step of one major cycle, a phase index output, and a busy flag.
- Feeds the phase enables of the CPU datapath and the O_S sync strobe used by bus and IO timing.

Parameters:
- PHASES, 2, number of phase outputs; legal range 2..16.
- HIGH_CYC, 1, CLK cycles each phase output stays high; minimum 1, maximum 255.
- GAP_CYC, 1, all-low dead cycles after each phase; 0..255, where 0 means phases are back-to-back and never overlap.
- Derived: major cycle length MC = PHASES*(HIGH_CYC+GAP_CYC). With the defaults MC = 4, matching the CLK/4 two-phase timing.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  run request; sampled every cycle.
- STEP  in  1  single-cycle pulse; requests exactly one major cycle while stopped.
- PH  out  PHASES  phase enables; at most one bit set; registered.
- O_S  out  1  one-cycle sync strobe, high on the first cycle of PH[0] in each major cycle; registered.
- PH_IDX  out  $clog2(PHASES)  index of the current or most recent phase; registered.
- BUSY  out  1  high whenever the state is not IDLE.

Behaviour:
- States:
  - IDLE: all PH low.
  - HIGH: PH[PH_IDX] high.
  - GAP: all PH low.
- Reset (RST=1 at a rising edge) takes priority over everything: state=IDLE, PH=0, O_S=0, PH_IDX=0, BUSY=0, counters=0, step latch=0. Reset mid-phase truncates immediately; no completion is guaranteed.
- IDLE -> HIGH when EN=1 or STEP=1 is sampled. On the following cycle PH[0]=1, O_S=1, PH_IDX=0, BUSY=1, so start latency is 1 cycle. A STEP that starts the cycle sets the step latch.
- HIGH: a down-counter is loaded with HIGH_CYC-1. At terminal count:
  - if GAP_CYC>0, go to GAP with the counter loaded with GAP_CYC-1;
  - if GAP_CYC=0, go directly to the next phase's HIGH.
- End of GAP, or end of HIGH when GAP_CYC=0:
  - If PH_IDX<PHASES-1: PH_IDX++, go to HIGH.
  - If PH_IDX=PHASES-1 (major-cycle boundary): PH_IDX wraps to 0.
    - If EN=1 and the step latch is clear: go to HIGH with O_S=1 (continuous run, no extra cycle).
    - Otherwise: go to IDLE and clear the step latch. PH_IDX stays 0 in IDLE.
- EN is examined only at the major-cycle boundary. Dropping EN mid-cycle completes all remaining phases and gaps, so no runt phase ever occurs.
- STEP is ignored unless the state is IDLE. STEP with EN=1 in IDLE behaves as a single step and stops after one major cycle, even if EN stays high. A later IDLE with EN=1 then restarts normally one cycle later.
- O_S is high only in the first HIGH cycle of phase 0, so it pulses exactly once per major cycle.
- Invariant: popcount(PH) <= 1 in every cycle. Adjacent phases are separated by GAP_CYC low cycles.
- Counter width is $clog2(max(HIGH_CYC,GAP_CYC)+1), minimum 1.
- Out-of-range parameters are flagged by an elaboration-time check.

Decomposition:
- Shared package clkgen_pkg:
  - state enum {IDLE, HIGH, GAP};
  - width helper function cnt_w(HIGH_CYC, GAP_CYC);
  - localparam for default PHASES.
- One natural sub-module, phase_timer: a loadable down-counter with a terminal-count flag, reused for the HIGH and GAP intervals.
- The top module holds the FSM, PH_IDX, the step latch and the output registers.

Test Plan:
- Defaults, RST 2 cycles, EN=1 held -> PH sequence 01,00,10,00 repeating with period 4; O_S high once per 4 cycles, aligned with PH=01; BUSY=1.
- PHASES=4, HIGH_CYC=3, GAP_CYC=2, EN=1 -> each PH bit high for 3 cycles then 2 low; MC=20; PH_IDX steps 0,1,2,3,0.
- GAP_CYC=0, PHASES=3, HIGH_CYC=2 -> PH = 001,001,010,010,100,100 repeating; never two bits set; O_S every 6 cycles.
- Defaults, EN dropped on the second cycle of a major cycle -> remaining phase and gaps complete, then IDLE with PH=0 and BUSY=0 exactly at the boundary.
- EN=0, STEP pulse -> one full major cycle (4 cycles, one O_S), then IDLE. STEP asserted while BUSY is ignored. STEP together with EN=1 -> still stops after one cycle.
- RST asserted during PH[1] high -> next cycle all outputs 0 and state IDLE. With EN=1 after RST release -> PH[0] rises 1 cycle later with O_S=1.
